ast_upum_core: RTL and testbench

UART-controlled command front end of the AST UPUM board controller.
- Receives 8N1 serial packets on rx and parses them into a framed, addressed byte stream (addr, my_tx_data, my_tx_valid) for the downstream peripheral blocks.
- Answers system commands sent to address 0x00 with reply packets on tx, including a status snapshot of comparator and GPIO lines.

---
 rtl/ast_upum_core.sv | 233 +++++++++++++++++++++++
 tb/tb_ast_upum_core.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ast_upum_core.sv
// UART command front end: parses EE/addr/len/payload/crc packets from rx into a
// strobed byte stream and answers identity/status commands for address 0x00 on tx.
module ast_upum_core #(
    parameter int SYS_CLK      = 100,
    parameter int BAUDRATE     = 115200,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic       clk_100,
    input  logic       rst_n,
    input  logic       rx,
    output logic       tx,
    output logic [6:0] addr,
    output logic [7:0] my_tx_data,
    output logic       my_tx_valid,
    input  logic [3:0] cmp_o,
    input  logic       gpio_o_144_159,
    input  logic       gpio_o_128_143,
    input  logic       gpio_o_112_127,
    input  logic       gpio_o_96_111,
    input  logic       gpio_o_80_95,
    input  logic       gpio_o_64_79,
    input  logic       gpio_o_48_63,
    input  logic       gpio_o_32_47,
    input  logic       gpio_o_16_31,
    input  logic       gpio_o_0_15
);
    localparam int CPB = (SYS_CLK * 1000000) / BAUDRATE;
    localparam int CW  = $clog2(CPB + 1);
    localparam logic [CW-1:0] CPB_M1  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
    localparam int TW  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_LEN, P_DATA, P_CRC} p_st_t;

    // ---------------- UART RX ----------------
    logic [2:0]    r_rx_sync;   // [1:0] synchroniser, [2] previous synced value
    rx_st_t        r_rx_st;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;
    logic [7:0]    r_rx_byte;
    logic          r_rx_vld;
    logic          r_rx_ferr;
    logic          w_rx;
    logic          w_fall;

    assign w_rx   = r_rx_sync[1];
    assign w_fall = r_rx_sync[2] & ~r_rx_sync[1];

    // Synchronise rx and keep one extra stage for falling-edge detection
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) r_rx_sync <= 3'b111;
        else        r_rx_sync <= {r_rx_sync[1:0], rx};
    end

    // Receive 8N1 bytes: verify start at half bit, sample data and stop at bit centres
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_st   <= RX_IDLE;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
            r_rx_byte <= '0;
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
        end else begin
            r_rx_vld  <= 1'b0;
            r_rx_ferr <= 1'b0;
            case (r_rx_st)
                RX_IDLE: if (w_fall) begin
                    r_rx_st  <= RX_START;
                    r_rx_cnt <= '0;
                end
                RX_START: if (r_rx_cnt == HALF_M1) begin
                    r_rx_cnt <= '0;
                    r_rx_bit <= '0;
                    r_rx_st  <= w_rx ? RX_IDLE : RX_DATA;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                RX_DATA: if (r_rx_cnt == CPB_M1) begin
                    r_rx_cnt <= '0;
                    r_rx_sh  <= {w_rx, r_rx_sh[7:1]};
                    if (r_rx_bit == 3'd7) r_rx_st <= RX_STOP;
                    r_rx_bit <= r_rx_bit + 1'b1;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
                default: if (r_rx_cnt == CPB_M1) begin
                    // Back to idle at stop centre so the next start edge is caught
                    r_rx_cnt <= '0;
                    r_rx_st  <= RX_IDLE;
                    if (w_rx) begin
                        r_rx_vld  <= 1'b1;
                        r_rx_byte <= r_rx_sh;
                    end else r_rx_ferr <= 1'b1;
                end else r_rx_cnt <= r_rx_cnt + 1'b1;
            endcase
        end
    end

    // ---------------- Packet parser ----------------
    p_st_t         r_p_st;
    logic [7:0]    r_len;
    logic [7:0]    r_cnt;
    logic [7:0]    r_cmd;
    logic [TW-1:0] r_tmo;
    logic          r_tx_busy;
    logic          w_launch;

    // Packet FSM with inter-byte timeout; forwards every payload byte as a strobe
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            r_p_st      <= P_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_tmo       <= '0;
            addr        <= '0;
            my_tx_data  <= '0;
            my_tx_valid <= 1'b0;
        end else begin
            my_tx_valid <= 1'b0;
            if (r_rx_ferr) begin
                r_p_st <= P_IDLE;
                r_tmo  <= '0;
            end else if (r_rx_vld) begin
                r_tmo <= '0;
                case (r_p_st)
                    P_IDLE: if (r_rx_byte == 8'hEE) r_p_st <= P_ADDR;
                    P_ADDR: begin
                        addr   <= r_rx_byte[6:0];
                        r_p_st <= P_LEN;
                    end
                    P_LEN: begin
                        r_len  <= r_rx_byte;
                        r_cnt  <= '0;
                        r_p_st <= (r_rx_byte == 8'd0) ? P_CRC : P_DATA;
                    end
                    P_DATA: begin
                        my_tx_data  <= r_rx_byte;
                        my_tx_valid <= 1'b1;
                        if (r_cnt == 8'd0) r_cmd <= r_rx_byte;
                        if (r_cnt == r_len - 8'd1) r_p_st <= P_CRC;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    default: r_p_st <= P_IDLE;
                endcase
            end else if (r_p_st != P_IDLE) begin
                if (r_tmo == TMO) begin
                    r_p_st <= P_IDLE;
                    r_tmo  <= '0;
                end else r_tmo <= r_tmo + 1'b1;
            end else r_tmo <= '0;
        end
    end

    // ---------------- Reply builder ----------------
    logic [6:0][7:0] w_rep;
    logic [2:0]      w_rep_n;
    logic [7:0]      w_s0, w_s1, w_s2;

    assign w_s0 = {4'b0, cmp_o};
    assign w_s1 = {gpio_o_144_159, gpio_o_128_143, gpio_o_112_127, gpio_o_96_111,
                   gpio_o_80_95, gpio_o_64_79, gpio_o_48_63, gpio_o_32_47};
    assign w_s2 = {6'b0, gpio_o_16_31, gpio_o_0_15};

    // CRC byte completing on a recognised command to address 0 while tx is free
    assign w_launch = r_rx_vld && (r_p_st == P_CRC) && (addr == 7'd0) && (r_len != 8'd0) &&
                      ((r_cmd == 8'hAE) || (r_cmd == 8'hF0)) && !r_tx_busy;

    // Assemble the reply packet; status inputs are captured when tx loads it
    always_comb begin
        w_rep   = '0;
        w_rep_n = 3'd5;
        w_rep[0] = 8'hEE;
        w_rep[1] = 8'h00;
        if (r_cmd == 8'hAE) begin
            w_rep[2] = 8'h01;
            w_rep[3] = 8'hAE;
            w_rep[4] = 8'h00 ^ 8'h01 ^ 8'hAE;
        end else begin
            w_rep_n  = 3'd7;
            w_rep[2] = 8'h03;
            w_rep[3] = w_s0;
            w_rep[4] = w_s1;
            w_rep[5] = w_s2;
            w_rep[6] = 8'h00 ^ 8'h03 ^ w_s0 ^ w_s1 ^ w_s2;
        end
    end

    // ---------------- UART TX ----------------
    logic [6:0][7:0] r_tx_buf;
    logic [2:0]      r_tx_n;
    logic [2:0]      r_tx_idx;
    logic [3:0]      r_tx_bit;
    logic [CW-1:0]   r_tx_cnt;

    // Serialise the buffered reply; bytes back-to-back, tx registered and idle high
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            tx        <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_buf  <= '0;
            r_tx_n    <= '0;
            r_tx_idx  <= '0;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
        end else if (w_launch) begin
            r_tx_buf  <= w_rep;
            r_tx_n    <= w_rep_n;
            r_tx_idx  <= '0;
            r_tx_bit  <= '0;
            r_tx_cnt  <= '0;
            r_tx_busy <= 1'b1;
            tx        <= 1'b0;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == CPB_M1) begin
                r_tx_cnt <= '0;
                if (r_tx_bit == 4'd9) begin
                    if (r_tx_idx == r_tx_n - 3'd1) begin
                        r_tx_busy <= 1'b0;
                    end else begin
                        r_tx_idx <= r_tx_idx + 1'b1;
                        r_tx_bit <= '0;
                        tx       <= 1'b0;
                    end
                end else begin
                    r_tx_bit <= r_tx_bit + 1'b1;
                    tx <= (r_tx_bit == 4'd8) ? 1'b1 : r_tx_buf[r_tx_idx][r_tx_bit[2:0]];
                end
            end else r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ast_upum_core.sv
// Randomised packet bench for ast_upum_core with a packet-level reference model.
module tb_ast_upum_core;
    localparam int SYS_CLK = 1;
    localparam int BAUD    = 62500;
    localparam int TMO     = 400;
    localparam int CPB     = (SYS_CLK * 1000000) / BAUD;  // 16 clocks per bit

    logic       clk_100 = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rx      = 1'b1;
    logic       tx;
    logic [6:0] addr;
    logic [7:0] my_tx_data;
    logic       my_tx_valid;
    logic [3:0] cmp_o = '0;
    logic [9:0] g = '0;   // g[k] is the status bit of GPIO group 16*k

    always #5 clk_100 = ~clk_100;

    ast_upum_core #(.SYS_CLK(SYS_CLK), .BAUDRATE(BAUD), .TIMEOUT_CLKS(TMO)) dut (
        .clk_100(clk_100), .rst_n(rst_n), .rx(rx), .tx(tx), .addr(addr),
        .my_tx_data(my_tx_data), .my_tx_valid(my_tx_valid), .cmp_o(cmp_o),
        .gpio_o_144_159(g[9]), .gpio_o_128_143(g[8]), .gpio_o_112_127(g[7]),
        .gpio_o_96_111(g[6]), .gpio_o_80_95(g[5]), .gpio_o_64_79(g[4]),
        .gpio_o_48_63(g[3]), .gpio_o_32_47(g[2]), .gpio_o_16_31(g[1]),
        .gpio_o_0_15(g[0]));

    int checks = 0, failures = 0;
    int tx_starts = 0, replies_done = 0, rst_cnt = 0;
    logic [14:0] got_strb[$], exp_strb[$];
    logic [7:0]  got_tx[$], exp_tx[$], pkt[$];
    bit exp_reply;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_100);
    endtask

    // Strobe capture: each clock with valid high is one forwarded byte
    always @(negedge clk_100) if (rst_n && my_tx_valid) got_strb.push_back({addr, my_tx_data});
    always @(negedge rst_n) rst_cnt++;

    // TX capture: checks each bit holds a full bit period and bytes are back-to-back
    initial begin : txmon
        logic prev, a, b, bad, more;
        logic [7:0] byt;
        logic [7:0] rep[$];
        int r0;
        prev = 1'b1;
        byt  = '0;
        forever begin
            @(negedge clk_100);
            if (rst_n && prev && !tx) begin
                tx_starts++;
                r0 = rst_cnt; bad = 1'b0; more = 1'b1; rep.delete();
                while (more) begin
                    for (int i = 0; i < 10; i++) begin
                        @(negedge clk_100); a = tx;
                        repeat (CPB - 3) @(negedge clk_100); b = tx;
                        repeat (2) @(negedge clk_100);
                        if (a !== b) bad = 1'b1;
                        if (i == 0 && a !== 1'b0) bad = 1'b1;
                        if (i == 9 && a !== 1'b1) bad = 1'b1;
                        if (i >= 1 && i <= 8) byt[i-1] = a;
                    end
                    rep.push_back(byt);
                    more = (tx === 1'b0) && (rst_cnt == r0);
                end
                if (rst_cnt == r0) begin
                    chk("tx_frame", bad, 0);
                    foreach (rep[k]) got_tx.push_back(rep[k]);
                    replies_done++;
                end
            end
            prev = tx;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0; wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin rx = b[i]; wait_clks(CPB); end
        rx = stop_ok; wait_clks(CPB);
        rx = 1'b1;
        if (!stop_ok) wait_clks(CPB);
    endtask

    task automatic send_pkt(input int maxgap);
        foreach (pkt[i]) begin
            send_byte(pkt[i], 1'b1);
            wait_clks($urandom_range(0, maxgap));
        end
    endtask

    // Reference: payload bytes are forwarded; cmd AE/F0 to addr 0 earns a reply
    task automatic model_pkt(input bit tx_busy);
        logic [6:0] a;
        int len;
        logic [7:0] s0, s1, s2, x;
        a = pkt[1][6:0];
        len = int'(pkt[2]);
        for (int i = 0; i < len; i++) exp_strb.push_back({a, pkt[3+i]});
        exp_reply = (a == 0) && (len > 0) && (pkt[3] == 8'hAE || pkt[3] == 8'hF0) && !tx_busy;
        if (!exp_reply) return;
        s0 = {4'b0, cmp_o};
        s1 = '0;
        for (int k = 0; k < 8; k++) s1[k] = g[k+2];
        s2 = {6'b0, g[1], g[0]};
        exp_tx.push_back(8'hEE); exp_tx.push_back(8'h00);
        if (pkt[3] == 8'hAE) begin
            exp_tx.push_back(8'h01); exp_tx.push_back(8'hAE);
        end else begin
            exp_tx.push_back(8'h03); exp_tx.push_back(s0);
            exp_tx.push_back(s1); exp_tx.push_back(s2);
        end
        x = 8'h00;
        for (int i = 1; i < exp_tx.size(); i++) x ^= exp_tx[i];
        exp_tx.push_back(x);
    endtask

    task automatic check_strobes(input string tag);
        chk({tag, "_nstrb"}, got_strb.size(), exp_strb.size());
        for (int i = 0; i < got_strb.size() && i < exp_strb.size(); i++)
            chk({tag, "_strb"}, got_strb[i], exp_strb[i]);
        got_strb.delete(); exp_strb.delete();
    endtask

    task automatic check_reply(input string tag, input int r0, input int s0);
        if (exp_reply) begin
            for (int k = 0; k < 3000 && replies_done == r0; k++) wait_clks(1);
            chk({tag, "_reply_done"}, replies_done - r0, 1);
            chk({tag, "_reply_len"}, got_tx.size(), exp_tx.size());
            for (int i = 0; i < got_tx.size() && i < exp_tx.size(); i++)
                chk({tag, "_reply_byte"}, got_tx[i], exp_tx[i]);
        end else begin
            wait_clks(40);
            chk({tag, "_no_reply"}, tx_starts - s0, 0);
        end
        got_tx.delete(); exp_tx.delete();
    endtask

    task automatic run_pkt(input string tag, input int maxgap);
        int r0, s0;
        r0 = replies_done; s0 = tx_starts;
        send_pkt(maxgap);
        model_pkt(1'b0);
        check_strobes(tag);
        check_reply(tag, r0, s0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int r0, s0, len;
        logic [7:0] b;
        wait_clks(4);
        chk("rst_tx", tx, 1); chk("rst_addr", addr, 0);
        chk("rst_data", my_tx_data, 0); chk("rst_valid", my_tx_valid, 0);
        rst_n = 1'b1;
        wait_clks(20);

        pkt = '{8'hEE, 8'h09, 8'h02, 8'h16, 8'h1D, 8'hCC};
        run_pkt("t1", 5);
        chk("t1_addr", addr, 7'h09);

        pkt = '{8'hEE, 8'h29, 8'h07, 8'hA0, 8'h02, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCC};
        run_pkt("t2a", 5);
        pkt = '{8'hEE, 8'h18, 8'h01, 8'h09, 8'hCC};
        run_pkt("t2b", 5);
        chk("t2_addr", addr, 7'h18);

        pkt = '{8'hEE, 8'h00, 8'h01, 8'hAE, 8'hCC};
        run_pkt("t3", 5);

        cmp_o = 4'd6; g = 10'b1010101010;
        pkt = '{8'hEE, 8'h00, 8'h01, 8'hF0, 8'hCC};
        run_pkt("t4", 5);

        // Timeout aborts the first packet after its only payload byte
        pkt = '{8'hEE, 8'h0A, 8'h02, 8'hA0};
        send_pkt(5);
        exp_strb.push_back({7'h0A, 8'hA0});
        wait_clks(TMO + 200);
        pkt = '{8'hEE, 8'h0B, 8'h02, 8'hA0, 8'h50, 8'hCC};
        run_pkt("t5", 5);

        // Framing error mid-payload; following non-EE bytes are ignored
        s0 = tx_starts;
        pkt = '{8'hEE, 8'h0C, 8'h03, 8'h11};
        send_pkt(5);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b1);
        send_byte(8'hCC, 1'b1);
        wait_clks(40);
        exp_strb.push_back({7'h0C, 8'h11});
        check_strobes("t6f");
        chk("t6f_no_reply", tx_starts - s0, 0);

        // Short low glitch is not a start bit
        rx = 1'b0; wait_clks(3); rx = 1'b1; wait_clks(CPB * 2);
        pkt = '{8'hEE, 8'h31, 8'h01, 8'h7E, 8'hCC};
        run_pkt("glitch", 3);

        // Second request completes while the first reply is still on the line
        r0 = replies_done; s0 = tx_starts;
        pkt = '{8'hEE, 8'h00, 8'h01, 8'hF0, 8'hCC};
        send_pkt(0);
        model_pkt(1'b0);
        pkt = '{8'hEE, 8'h00, 8'h01, 8'hAE, 8'hCC};
        send_pkt(0);
        model_pkt(1'b1);
        exp_reply = 1'b1;
        check_strobes("busy");
        check_reply("busy", r0, s0);
        wait_clks(1400);
        chk("busy_one_start", tx_starts - s0, 1);

        // Reset during a reply
        r0 = replies_done; s0 = tx_starts;
        pkt = '{8'hEE, 8'h00, 8'h01, 8'hAE, 8'hCC};
        send_pkt(2);
        for (int k = 0; k < 200 && tx_starts == s0; k++) wait_clks(1);
        chk("rst_mid_started", tx_starts - s0, 1);
        wait_clks(300);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_tx", tx, 1);
        chk("rst_mid_valid", my_tx_valid, 0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(CPB * 12);
        chk("rst_mid_no_done", replies_done - r0, 0);
        got_tx.delete(); got_strb.delete(); exp_strb.delete();
        pkt = '{8'hEE, 8'h00, 8'h01, 8'hAE, 8'hCC};
        run_pkt("after_rst", 4);

        // Random packets
        for (int n = 0; n < 10; n++) begin
            cmp_o = 4'($urandom); g = 10'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom_range(0, 8'hED));
                send_byte(b, 1'b1);
            end
            len = $urandom_range(0, 4);
            pkt.delete();
            pkt.push_back(8'hEE);
            b = {1'($urandom), ($urandom_range(0, 2) == 0) ? 7'h00 : 7'($urandom)};
            pkt.push_back(b);
            pkt.push_back(8'(len));
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 2))
                    0: b = 8'hAE;
                    1: b = 8'hF0;
                    default: b = 8'($urandom);
                endcase
                pkt.push_back(b);
            end
            pkt.push_back(8'($urandom));
            run_pkt("rnd", 20);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
